// File: rtl/sync_fifo.sv
// Single-clock FIFO: DEPTH x DATA_WIDTH storage with wrap-flag pointers and a registered read port.
// Latency: one clock from an accepted read to valid data_out; flags are combinational from the pointers.
// Backpressure: writes are dropped while full and reads while empty; callers watch full/empty.
//
// Ports:
//   clk      - single clock, all state updates on its rising edge
//   reset    - synchronous, active-high; clears pointers and data_out (memory is left as is)
//   wr_en    - write request, accepted when full is low
//   data_in  - write data
//   rd_en    - read request, accepted when empty is low
//   data_out - registered read data, holds its value when no read is accepted
//   full     - DEPTH entries stored
//   empty    - no entries stored
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  // Storage; deliberately has no reset so a reset only discards entries logically.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // One extra MSB on each pointer distinguishes full from empty when the
  // address bits match.
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;

  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;

  logic wr_fire;
  logic rd_fire;

  assign wr_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign rd_addr = rd_ptr[ADDR_WIDTH-1:0];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_addr == rd_addr);

  // Acceptance uses the flags as they stand before the edge. Read and write
  // with both flags low update together; when full only the read fires, when
  // empty only the write fires, so the read never sees a same-edge write.
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;

  // Memory write is gated by reset so reset wins over a concurrent write.
  always_ff @(posedge clk) begin
    if (!reset && wr_fire) begin
      mem[wr_addr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      data_out <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_addr];
      end
    end
  end

`ifndef SYNTHESIS
  // Occupancy is the modulo-2*DEPTH pointer difference and can never exceed DEPTH.
  logic [ADDR_WIDTH:0] occupancy;
  assign occupancy = wr_ptr - rd_ptr;

  a_flags_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(full && empty));

  a_occupancy_bound: assert property (@(posedge clk) disable iff (reset)
    occupancy <= (ADDR_WIDTH+1)'(DEPTH));

  a_full_blocks_write: assert property (@(posedge clk) disable iff (reset)
    (full && wr_en && !rd_en) |=> $stable(wr_ptr));

  a_empty_blocks_read: assert property (@(posedge clk) disable iff (reset)
    (empty && rd_en) |=> ($stable(rd_ptr) && $stable(data_out)));
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: one task per scenario with inline comparisons
// against a small queue model that tracks contents, pointers and data_out.
module tb_sync_fifo;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int checks;
  int passed;

  // Reference model state.
  logic [7:0] q[$];
  logic [4:0] exp_wr;
  logic [4:0] exp_rd;
  logic [7:0] exp_dout;

  sync_fifo #(
    .DATA_WIDTH(8),
    .DEPTH(16),
    .ADDR_WIDTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .data_in(data_in),
    .data_out(data_out),
    .full(full),
    .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of requests, advance past the edge and update the model.
  task automatic step(input logic we, input logic re, input logic [7:0] din);
    logic wr_ok;
    logic rd_ok;
    wr_en   = we;
    rd_en   = re;
    data_in = din;
    wr_ok   = we && (q.size() < 16);
    rd_ok   = re && (q.size() > 0);
    @(posedge clk);
    #1;
    if (rd_ok) begin
      exp_dout = q.pop_front();
      exp_rd   = exp_rd + 5'd1;
    end
    if (wr_ok) begin
      q.push_back(din);
      exp_wr = exp_wr + 5'd1;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    exp_wr = '0; exp_rd = '0; exp_dout = '0;
    checks++; if (data_out !== 8'h00) $display("FAIL reset_dout: got %h expected 00", data_out); else passed++;
    checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", empty); else passed++;
    checks++; if (full !== 1'b0) $display("FAIL reset_full: got %b expected 0", full); else passed++;
  endtask

  task automatic test_write_read();
    logic [7:0] vec [10];
    vec = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12, 8'h01, 8'h0D};
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, vec[i]);
      if (i == 0) begin
        checks++; if (empty !== 1'b0) $display("FAIL wr_first_empty: got %b expected 0", empty); else passed++;
      end
    end
    checks++; if (full !== 1'b0) $display("FAIL wr10_full: got %b expected 0", full); else passed++;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 8'h00);
      checks++; if (data_out !== vec[i]) $display("FAIL rd_seq[%0d]: got %h expected %h", i, data_out, vec[i]); else passed++;
    end
    checks++; if (empty !== 1'b1) $display("FAIL rd10_empty: got %b expected 1", empty); else passed++;
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i));
      if (i == 14) begin
        checks++; if (full !== 1'b0) $display("FAIL full_at15: got %b expected 0", full); else passed++;
      end
    end
    checks++; if (full !== 1'b1) $display("FAIL full_at16: got %b expected 1", full); else passed++;
    step(1'b1, 1'b0, 8'hFF);
    checks++; if (full !== 1'b1) $display("FAIL full_after_ovf: got %b expected 1", full); else passed++;
    checks++; if (dut.wr_ptr !== exp_wr) $display("FAIL ovf_wr_ptr: got %h expected %h", dut.wr_ptr, exp_wr); else passed++;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      checks++; if (data_out !== 8'(i)) $display("FAIL full_drain[%0d]: got %h expected %h", i, data_out, 8'(i)); else passed++;
    end
    checks++; if (empty !== 1'b1) $display("FAIL full_drain_empty: got %b expected 1", empty); else passed++;
  endtask

  task automatic test_read_empty();
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'h0F) $display("FAIL rdempty_dout: got %h expected 0f", data_out); else passed++;
    checks++; if (dut.rd_ptr !== exp_rd) $display("FAIL rdempty_rd_ptr: got %h expected %h", dut.rd_ptr, exp_rd); else passed++;
    checks++; if (dut.wr_ptr !== exp_wr) $display("FAIL rdempty_wr_ptr: got %h expected %h", dut.wr_ptr, exp_wr); else passed++;
    checks++; if (empty !== 1'b1) $display("FAIL rdempty_empty: got %b expected 1", empty); else passed++;
  endtask

  task automatic test_simul_edges();
    // Both requests while empty: only the write happens.
    step(1'b1, 1'b1, 8'h5A);
    checks++; if (empty !== 1'b0) $display("FAIL simul_empty_flag: got %b expected 0", empty); else passed++;
    checks++; if (data_out !== 8'h0F) $display("FAIL simul_empty_dout: got %h expected 0f", data_out); else passed++;
    step(1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'h5A) $display("FAIL simul_empty_rd: got %h expected 5a", data_out); else passed++;
    // Both requests while full: only the read happens.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'h80 + 8'(i));
    step(1'b1, 1'b1, 8'hEE);
    checks++; if (data_out !== 8'h80) $display("FAIL simul_full_rd: got %h expected 80", data_out); else passed++;
    checks++; if (full !== 1'b0) $display("FAIL simul_full_flag: got %b expected 0", full); else passed++;
    checks++; if (dut.wr_ptr !== exp_wr) $display("FAIL simul_full_wr_ptr: got %h expected %h", dut.wr_ptr, exp_wr); else passed++;
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      checks++; if (data_out !== 8'h80 + 8'(i)) $display("FAIL simul_full_drain[%0d]: got %h expected %h", i, data_out, 8'h80 + 8'(i)); else passed++;
    end
    checks++; if (empty !== 1'b1) $display("FAIL simul_full_empty: got %b expected 1", empty); else passed++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h30 + 8'(i));
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 8'h40 + 8'(i));
      if (i < 8) begin
        checks++; if (data_out !== 8'h30 + 8'(i)) $display("FAIL b2b_old[%0d]: got %h expected %h", i, data_out, 8'h30 + 8'(i)); else passed++;
      end else begin
        checks++; if (data_out !== 8'h40 + 8'(i - 8)) $display("FAIL b2b_new[%0d]: got %h expected %h", i, data_out, 8'h40 + 8'(i - 8)); else passed++;
      end
      checks++; if (5'(dut.wr_ptr - dut.rd_ptr) !== 5'd8) $display("FAIL b2b_occ[%0d]: got %0d expected 8", i, 5'(dut.wr_ptr - dut.rd_ptr)); else passed++;
    end
    checks++; if (dut.rd_ptr !== exp_rd) $display("FAIL b2b_rd_ptr: got %h expected %h", dut.rd_ptr, exp_rd); else passed++;
    checks++; if (dut.wr_ptr !== exp_wr) $display("FAIL b2b_wr_ptr: got %h expected %h", dut.wr_ptr, exp_wr); else passed++;
    for (int i = 12; i < 20; i++) begin
      step(1'b0, 1'b1, 8'h00);
      checks++; if (data_out !== 8'h40 + 8'(i)) $display("FAIL b2b_drain[%0d]: got %h expected %h", i, data_out, 8'h40 + 8'(i)); else passed++;
    end
    checks++; if (empty !== 1'b1) $display("FAIL b2b_empty: got %b expected 1", empty); else passed++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'hA0 + 8'(i));
    step(1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'hA0) $display("FAIL mid_pre_dout: got %h expected a0", data_out); else passed++;
    // Reset together with both requests: reset must win.
    reset   = 1'b1;
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    data_in = 8'h77;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    q.delete();
    exp_wr = '0; exp_rd = '0; exp_dout = '0;
    checks++; if (empty !== 1'b1) $display("FAIL mid_empty: got %b expected 1", empty); else passed++;
    checks++; if (full !== 1'b0) $display("FAIL mid_full: got %b expected 0", full); else passed++;
    checks++; if (data_out !== 8'h00) $display("FAIL mid_dout: got %h expected 00", data_out); else passed++;
    checks++; if (dut.wr_ptr !== 5'd0) $display("FAIL mid_wr_ptr: got %h expected 00", dut.wr_ptr); else passed++;
    step(1'b0, 1'b1, 8'h00);
    checks++; if (data_out !== 8'h00) $display("FAIL mid_rd_dout: got %h expected 00", data_out); else passed++;
    checks++; if (dut.rd_ptr !== 5'd0) $display("FAIL mid_rd_ptr: got %h expected 00", dut.rd_ptr); else passed++;
    checks++; if (empty !== 1'b1) $display("FAIL mid_rd_empty: got %b expected 1", empty); else passed++;
  endtask

  initial begin
    checks  = 0;
    passed  = 0;
    reset   = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = 8'h00;
    exp_wr  = '0;
    exp_rd  = '0;
    exp_dout = '0;
    test_reset();
    test_write_read();
    test_full();
    test_read_empty();
    test_simul_edges();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
